// File: rtl/traffic_sched.sv
// Two-street traffic light scheduler with actuated greens, pedestrian latches and walk signals.
// All state advances on prescaled timing ticks; every output is registered.
module traffic_sched #(
    parameter int TICK_DIV = 4,
    parameter int GMIN     = 3,
    parameter int GMAX     = 6,
    parameter int YLEN     = 2,
    parameter int RLEN     = 1
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       SA,
    input  logic       SB,
    input  logic       PA,
    input  logic       PB,
    output logic       GA,
    output logic       YA,
    output logic       RA,
    output logic       GB,
    output logic       YB,
    output logic       RB,
    output logic       WALKA,
    output logic       WALKB,
    output logic [2:0] PHASE
);
    typedef enum logic [2:0] {
        S_GA  = 3'd0,
        S_YA  = 3'd1,
        S_RAB = 3'd2,
        S_GB  = 3'd3,
        S_YB  = 3'd4,
        S_RBA = 3'd5
    } phase_e;

    localparam int            PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [8:0]    GMIN_E  = 9'(GMIN);
    localparam logic [8:0]    GMAX_E  = 9'(GMAX);
    localparam logic [8:0]    YLEN_E  = 9'(YLEN);
    localparam logic [8:0]    RLEN_E  = 9'(RLEN);

    phase_e        state_q, state_d;
    logic [PW-1:0] ps_q, ps_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          pla_q, pla_d, plb_q, plb_d;
    logic          walka_q, walka_d, walkb_q, walkb_d;
    logic [5:0]    lamp_q, lamp_d;   // {GA,YA,RA,GB,YB,RB}
    logic          tick, dem_a, dem_b, enter_ga, enter_gb;
    logic [8:0]    elapsed;

    always_comb begin
        tick    = (ps_q == PS_LAST);
        ps_d    = tick ? '0 : ps_q + 1'b1;
        dem_a   = SA | plb_q;
        dem_b   = SB | pla_q;
        elapsed = {1'b0, cnt_q} + 9'd1;

        state_d = state_q;
        case (state_q)
            S_GA:  if (tick && elapsed >= GMIN_E && dem_b && (!dem_a || elapsed >= GMAX_E)) state_d = S_YA;
            S_YA:  if (tick && elapsed == YLEN_E) state_d = S_RAB;
            S_RAB: if (tick && elapsed == RLEN_E) state_d = S_GB;
            S_GB:  if (tick && elapsed >= GMIN_E && dem_a && (!dem_b || elapsed >= GMAX_E)) state_d = S_YB;
            S_YB:  if (tick && elapsed == YLEN_E) state_d = S_RBA;
            S_RBA: if (tick && elapsed == RLEN_E) state_d = S_GA;
            default: state_d = S_GA;
        endcase

        enter_ga = (state_d == S_GA) && (state_q != S_GA);
        enter_gb = (state_d == S_GB) && (state_q != S_GB);

        if (state_d != state_q)        cnt_d = '0;
        else if (tick && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        else                           cnt_d = cnt_q;

        // A press coinciding with the clearing edge keeps the latch set.
        pla_d   = PA | (pla_q & ~enter_gb);
        plb_d   = PB | (plb_q & ~enter_ga);
        walka_d = enter_gb ? pla_q : ((state_d == S_GB) ? walka_q : 1'b0);
        walkb_d = enter_ga ? plb_q : ((state_d == S_GA) ? walkb_q : 1'b0);

        case (state_d)
            S_YA:         lamp_d = 6'b010001;
            S_RAB, S_RBA: lamp_d = 6'b001001;
            S_GB:         lamp_d = 6'b001100;
            S_YB:         lamp_d = 6'b001010;
            default:      lamp_d = 6'b100001;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= S_GA;
            ps_q    <= '0;
            cnt_q   <= '0;
            pla_q   <= 1'b0;
            plb_q   <= 1'b0;
            walka_q <= 1'b0;
            walkb_q <= 1'b0;
            lamp_q  <= 6'b100001;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            cnt_q   <= cnt_d;
            pla_q   <= pla_d;
            plb_q   <= plb_d;
            walka_q <= walka_d;
            walkb_q <= walkb_d;
            lamp_q  <= lamp_d;
        end
    end

    assign {GA, YA, RA, GB, YB, RB} = lamp_q;
    assign WALKA = walka_q;
    assign WALKB = walkb_q;
    assign PHASE = state_q;
endmodule

// File: tb/tb_traffic_sched.sv
// Randomized + directed bench for traffic_sched: a tick/elapsed-time reference model
// pushes expected outputs per edge; a negedge monitor pops and compares.
module tb_traffic_sched;
    localparam int TD = 4, GMIN = 3, GMAX = 6, YLEN = 2, RLEN = 1;

    logic CLK = 1'b0, RSTN = 1'b0;
    logic SA = 1'b0, SB = 1'b0, PA = 1'b0, PB = 1'b0;
    logic GA, YA, RA, GB, YB, RB, WALKA, WALKB;
    logic [2:0] PHASE;

    traffic_sched #(.TICK_DIV(TD), .GMIN(GMIN), .GMAX(GMAX), .YLEN(YLEN), .RLEN(RLEN)) dut (
        .CLK(CLK), .RSTN(RSTN), .SA(SA), .SB(SB), .PA(PA), .PB(PB),
        .GA(GA), .YA(YA), .RA(RA), .GB(GB), .YB(YB), .RB(RB),
        .WALKA(WALKA), .WALKB(WALKB), .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    int nchk = 0, nerr = 0;

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Lamp word {GA,YA,RA,GB,YB,RB} required for each phase.
    function automatic int lamps_of(input int ph);
        case (ph)
            0:       return 6'b100001;
            1:       return 6'b010001;
            2, 5:    return 6'b001001;
            3:       return 6'b001100;
            4:       return 6'b001010;
            default: return -1;
        endcase
    endfunction

    typedef struct { int ph; int wa; int wb; } exp_t;
    exp_t q[$];

    // Reference model: counts edges since reset and elapsed ticks in the current phase.
    int m_ph = 0, m_el = 0, m_cyc = 0;
    int m_pla = 0, m_plb = 0, m_wa = 0, m_wb = 0;

    always @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m_ph = 0; m_el = 0; m_cyc = 0;
            m_pla = 0; m_plb = 0; m_wa = 0; m_wb = 0;
            q.delete();
        end else begin
            int nxt, e, da, db;
            bit tk;
            exp_t x;
            tk  = (m_cyc % TD) == TD - 1;
            m_cyc++;
            da  = int'(SA) | m_plb;
            db  = int'(SB) | m_pla;
            e   = m_el + 1;
            nxt = m_ph;
            if (tk) begin
                case (m_ph)
                    0: if (e >= GMIN && db == 1 && (da == 0 || e >= GMAX)) nxt = 1;
                    1: if (e == YLEN) nxt = 2;
                    2: if (e == RLEN) nxt = 3;
                    3: if (e >= GMIN && da == 1 && (db == 0 || e >= GMAX)) nxt = 4;
                    4: if (e == YLEN) nxt = 5;
                    5: if (e == RLEN) nxt = 0;
                    default: nxt = 0;
                endcase
            end
            if (nxt == 3 && m_ph != 3) m_wa = m_pla; else if (nxt != 3) m_wa = 0;
            if (nxt == 0 && m_ph != 0) m_wb = m_plb; else if (nxt != 0) m_wb = 0;
            m_pla = (PA ? 1 : 0) | ((nxt == 3 && m_ph != 3) ? 0 : m_pla);
            m_plb = (PB ? 1 : 0) | ((nxt == 0 && m_ph != 0) ? 0 : m_plb);
            if (nxt != m_ph) m_el = 0; else if (tk) m_el++;
            m_ph = nxt;
            x.ph = m_ph; x.wa = m_wa; x.wb = m_wb;
            q.push_back(x);
        end
    end

    always @(negedge CLK) begin
        if (!RSTN) begin
            chk("rst_phase", int'(PHASE), 0);
            chk("rst_lamps", int'({GA, YA, RA, GB, YB, RB}), lamps_of(0));
            chk("rst_walk", int'({WALKA, WALKB}), 0);
        end else if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk("phase", int'(PHASE), x.ph);
            chk("lamps", int'({GA, YA, RA, GB, YB, RB}), lamps_of(x.ph));
            chk("walka", int'(WALKA), x.wa);
            chk("walkb", int'(WALKB), x.wb);
        end
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        #2 RSTN = 1'b0;
        SA = 0; SB = 0; PA = 0; PB = 0;
        #1;
        chk("async_rst_phase", int'(PHASE), 0);
        chk("async_rst_lamps", int'({GA, YA, RA, GB, YB, RB}), lamps_of(0));
        chk("async_rst_walk", int'({WALKA, WALKB}), 0);
        @(posedge CLK);
        #2 RSTN = 1'b1;
    endtask

    initial begin
        // Idle after reset: green A held.
        wait_edges(3);
        apply_reset();
        wait_edges(100);
        chk("idle_phase", int'(PHASE), 0);

        // Sensor B only.
        apply_reset();
        SB = 1;
        wait_edges(11); chk("sb_e11", int'(PHASE), 0);
        wait_edges(1);  chk("sb_e12", int'(PHASE), 1);
        wait_edges(8);  chk("sb_e20", int'(PHASE), 2);
        wait_edges(4);  chk("sb_e24", int'(PHASE), 3);
        wait_edges(40); chk("sb_hold", int'(PHASE), 3);

        // Both sensors: GMAX-limited alternation.
        apply_reset();
        SA = 1; SB = 1;
        wait_edges(23); chk("ab_e23", int'(PHASE), 0);
        wait_edges(1);  chk("ab_e24", int'(PHASE), 1);
        wait_edges(8);  chk("ab_e32", int'(PHASE), 2);
        wait_edges(4);  chk("ab_e36", int'(PHASE), 3);
        wait_edges(24); chk("ab_e60", int'(PHASE), 4);
        wait_edges(60);

        // Pedestrian A pulse at cycle 2, then another on the S_GB entry edge.
        apply_reset();
        wait_edges(1); PA = 1;
        wait_edges(1); PA = 0;
        wait_edges(21); chk("pa_e23", int'(PHASE), 2); PA = 1;
        wait_edges(1);  chk("pa_e24", int'(PHASE), 3); chk("pa_walka", int'(WALKA), 1); PA = 0;
        wait_edges(6);  SA = 1;
        wait_edges(100);

        // Reset mid-yellow clears latches; prescaler restarts.
        apply_reset();
        wait_edges(1); PA = 1;
        wait_edges(1); PA = 0; SB = 1;
        wait_edges(12); chk("mid_ya", int'(PHASE), 1);
        apply_reset();
        wait_edges(40); chk("post_rst_hold", int'(PHASE), 0);
        SB = 1;
        wait_edges(3); chk("post_rst_e43", int'(PHASE), 0);
        wait_edges(1); chk("post_rst_e44", int'(PHASE), 1);
        wait_edges(20);

        // Long idle green (counter saturation), then demand.
        apply_reset();
        wait_edges(1100);
        SB = 1;
        wait_edges(40);

        // Randomized traffic with occasional asynchronous resets.
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            SA = ($urandom_range(0, 9) < 3);
            SB = ($urandom_range(0, 9) < 3);
            PA = ($urandom_range(0, 19) == 0);
            PB = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) apply_reset();
            wait_edges(1);
        end
        SA = 0; SB = 0; PA = 0; PB = 0;
        wait_edges(2);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
